sdram_burst_writer: RTL and testbench
=====================================

// Module: sdram_burst_writer
// PURPOSE
//  Write-side companion of the SDRAM read path: initialises the SDRAM, then stores image words.
//  Producer logic hands over 32-bit pairs; each pair becomes one BL=2 write burst, with auto-precharge, at a sequential address.
//  The block issues periodic auto-refresh itself. It sits between the image-load logic and the SDRAM pins.
// PARAMETERS
//  INIT_CYCLES   14300  power-up NOP wait (100 us @ 143 MHz)
//  REFRESH_INT   1100   cycles between auto-refresh requests (< 7.8 us)
//  T_RP          3      PRECHARGE to next command, cycles
//  T_RCD         3      ACTIVATE to WRITE, cycles
//  T_RC          9      REFRESH/ACTIVATE to next ACTIVATE/REFRESH, cycles
//  T_WR          2      last write data to auto-precharge start, cycles
// PORTS
//  ck143      in   1   clock, shared with SDRAM
//  reset      in   1   synchronous, active-high
//  clear      in   1   sync pulse: write address counter back to 0
//  wr_valid   in   1   wr_data holds a word pair
//  wr_data    in   32  [15:0] first word, [31:16] second word
//  wr_ready   out  1   pair accepted when wr_valid & wr_ready
//  init_done  out  1   SDRAM initialisation complete (sticky until reset)
//  wr_addr    out  25  word address of next burst {row[12:0],bank[1:0],col[9:0]}
//  mem_dq     inout 16 SDRAM data; driven only in WRITE0/WRITE1, else 'z
//  mem_a      out  13  address;  mem_ba out 2 bank
//  mem_cke, mem_ldqm, mem_udqm, mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n  out 1 each
// BEHAVIOUR
//  - All outputs are registered. Commands change on the posedge of ck143.
//  - Reset values: cs_n=ras_n=cas_n=we_n=1, a=0, ba=0, cke=1, ldqm=udqm=0, dq='z,
//    wr_ready=0, init_done=0, wr_addr=0. State=INIT_WAIT, refresh counter=0, refresh pending=0.
//  - Reset mid-burst aborts immediately. No partial-burst completion. Full re-initialisation follows.
//  - Commands {cs_n,ras_n,cas_n,we_n}: NOP 0111, ACT 0011, WRITE 0100, PRE 0010, REF 0001, MRS 0000.
//  - Init sequence: INIT_WAIT (INIT_CYCLES NOPs) -> PRE_ALL (a[10]=1; T_RP) -> REF (T_RC) -> REF (T_RC)
//    -> MRS (a=13'b000_0_00_010_0_001: BL=2, sequential, CAS=2, burst write; then 2 NOPs) -> IDLE.
//    init_done rises on entering IDLE.
//  - IDLE: if refresh_pending -> REFRESH. Else wr_ready=1. On handshake, latch wr_data -> ACTIVATE.
//  - Refresh has priority: when pending, wr_ready=0 in that cycle, even if wr_valid=1.
//  - ACTIVATE: ba=wr_addr[11:10], a=wr_addr[24:12]. NOP for T_RCD-1 cycles -> WRITE0.
//  - WRITE0: WRITE, ba, a[9:0]=wr_addr[9:0], a[10]=1 (auto-precharge), dq=data[15:0].
//  - WRITE1: NOP, dq=data[31:16]. Then RECOVER: NOP for T_WR+T_RP cycles -> IDLE.
//    wr_addr += 2 on leaving WRITE1.
//  - Accepted-pair to next wr_ready: 1+(T_RCD-1)+2+T_WR+T_RP = 10 cycles at defaults (meets T_RC).
//  - REFRESH: REF command, NOP for T_RC-1 cycles -> IDLE. Clears refresh_pending.
//  - Refresh counter runs continuously once init_done=1. At REFRESH_INT-1 it wraps and sets pending.
//    If set while already pending, it stays set (a request may be absorbed; the interval margin covers this).
//  - wr_addr wraps 2^25-2 -> 0 silently. Column bit 0 is always 0 (pairs are aligned).
//  - clear is honoured in any state. It only zeroes wr_addr; a burst in flight completes at its
//    latched address. If clear and the address increment coincide, clear wins.
//  - ldqm=udqm=0 always. cke=1 always.
// STRUCTURE
//  - sdram_pkg (shared with the read controller): command encodings, MRS value, state enum, timing defaults.
//  - Sub-module sdram_refresh_timer (counter + pending flag, ack input).
//  - Top: FSM, address counter, data latch, tri-state dq driver.
// TESTING
//  1 Reset then run -> 14300 NOPs; PRE a[10]=1; REF x2, spaced 9 cycles; MRS a=0x021; init_done=1, wr_ready=1.
//  2 wr_data=0xBEEF_1234 at wr_addr=0 -> ACT ba=0 a=0; WRITE 3 cycles later with dq=0x1234, a[10]=1;
//    next cycle dq=0xBEEF; wr_addr=2; wr_ready again 10 cycles after accept.
//  3 Force wr_addr=0x1FFFFFE, write one pair -> ACT row 0x1FFF, bank 3; then wr_addr=0.
//  4 Hold wr_valid=1 continuously across a refresh expiry -> REF issued before the next ACT;
//    no handshake lost, data order preserved, dq='z during REF.
//  5 Assert reset during WRITE1 -> next cycle every output at its reset value, dq='z; init restarts.
//  6 Pulse clear in RECOVER after a write to address 6 -> wr_addr=0; next burst targets col 0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions for the read and write controllers:
// command encodings, mode register value, FSM states, timing defaults.
package sdram_pkg;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_DESL = 4'b1111;
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_REF  = 4'b0001;
   localparam logic [3:0] CMD_MRS  = 4'b0000;

   // BL=2, sequential, CAS=2, burst write
   localparam logic [12:0] MRS_VAL = 13'b000_0_00_010_0_001;

   localparam int D_INIT_CYCLES = 14300;
   localparam int D_REFRESH_INT = 1100;
   localparam int D_T_RP        = 3;
   localparam int D_T_RCD       = 3;
   localparam int D_T_RC        = 9;
   localparam int D_T_WR        = 2;

   typedef logic [3:0] sdram_state_t;

   localparam sdram_state_t S_INIT_WAIT = 4'd0;
   localparam sdram_state_t S_PRE_ALL   = 4'd1;
   localparam sdram_state_t S_REF1      = 4'd2;
   localparam sdram_state_t S_REF2      = 4'd3;
   localparam sdram_state_t S_MRS       = 4'd4;
   localparam sdram_state_t S_IDLE      = 4'd5;
   localparam sdram_state_t S_REFRESH   = 4'd6;
   localparam sdram_state_t S_ACTIVATE  = 4'd7;
   localparam sdram_state_t S_WRITE0    = 4'd8;
   localparam sdram_state_t S_WRITE1    = 4'd9;
   localparam sdram_state_t S_RECOVER   = 4'd10;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running auto-refresh interval counter with a sticky
// request flag that the controller clears by acknowledging.
module sdram_refresh_timer
   import sdram_pkg::*;
#(
   parameter int REFRESH_INT = D_REFRESH_INT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic ack_i,
   output logic pend_o,
   output logic pend_next_o
);

   localparam int W = $clog2(REFRESH_INT + 1);

   logic [W-1:0] cnt_q, cnt_d;
   logic         pend_q, pend_d;
   logic         wrap;

   // a new request beats a same-cycle acknowledge
   always_comb begin
      wrap   = en_i && (cnt_q == W'(REFRESH_INT - 1));
      cnt_d  = cnt_q;
      if (en_i) cnt_d = wrap ? '0 : cnt_q + 1'b1;
      pend_d = wrap | (pend_q & ~ack_i);
   end

   // counter and request flag registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
      end
   end

   assign pend_o      = pend_q;
   assign pend_next_o = pend_d;

endmodule

// File: rtl/sdram_burst_writer.sv
// SDRAM write path: power-up init, periodic refresh, and one
// BL=2 auto-precharge write burst per accepted 32-bit pair.
module sdram_burst_writer
   import sdram_pkg::*;
#(
   parameter int INIT_CYCLES = D_INIT_CYCLES,
   parameter int REFRESH_INT = D_REFRESH_INT,
   parameter int T_RP        = D_T_RP,
   parameter int T_RCD       = D_T_RCD,
   parameter int T_RC        = D_T_RC,
   parameter int T_WR        = D_T_WR
) (
   input  logic        ck143,
   input  logic        reset,
   input  logic        clear,
   input  logic        wr_valid,
   input  logic [31:0] wr_data,
   output logic        wr_ready,
   output logic        init_done,
   output logic [24:0] wr_addr,
   inout  wire  [15:0] mem_dq,
   output logic [12:0] mem_a,
   output logic [1:0]  mem_ba,
   output logic        mem_cke,
   output logic        mem_ldqm,
   output logic        mem_udqm,
   output logic        mem_cs_n,
   output logic        mem_ras_n,
   output logic        mem_cas_n,
   output logic        mem_we_n
);

   localparam int CW = $clog2(INIT_CYCLES + 2);

   sdram_state_t state_q, state_d, succ;
   logic [CW-1:0] cnt_q, cnt_d, dwell;

   logic [3:0]  cmd_q, cmd_d;
   logic [12:0] a_q, a_d;
   logic [1:0]  ba_q, ba_d;
   logic        oe_q, oe_d;
   logic [15:0] dq_q, dq_d;
   logic        rdy_q, rdy_d;
   logic        init_q, init_d;
   logic [24:0] addr_q, addr_d;
   logic [24:0] baddr_q, baddr_d;
   logic [31:0] data_q, data_d;

   logic hs, ref_ack, ref_pend, ref_pend_d, first;

   sdram_refresh_timer #(
      .REFRESH_INT(REFRESH_INT)
   ) u_rt (
      .clk_i      (ck143),
      .rst_i      (reset),
      .en_i       (init_q),
      .ack_i      (ref_ack),
      .pend_o     (ref_pend),
      .pend_next_o(ref_pend_d)
   );

   // per-state dwell (cycles minus one) and successor
   always_comb begin
      dwell = '0;
      succ  = S_INIT_WAIT;
      unique case (state_q)
         S_INIT_WAIT: begin dwell = CW'(INIT_CYCLES);     succ = S_PRE_ALL;  end
         S_PRE_ALL:   begin dwell = CW'(T_RP - 1);        succ = S_REF1;     end
         S_REF1:      begin dwell = CW'(T_RC - 1);        succ = S_REF2;     end
         S_REF2:      begin dwell = CW'(T_RC - 1);        succ = S_MRS;      end
         S_MRS:       begin dwell = CW'(2);               succ = S_IDLE;     end
         S_IDLE:      begin dwell = '0;                   succ = S_IDLE;     end
         S_REFRESH:   begin dwell = CW'(T_RC - 1);        succ = S_IDLE;     end
         S_ACTIVATE:  begin dwell = CW'(T_RCD - 1);       succ = S_WRITE0;   end
         S_WRITE0:    begin dwell = '0;                   succ = S_WRITE1;   end
         S_WRITE1:    begin dwell = '0;                   succ = S_RECOVER;  end
         S_RECOVER:   begin dwell = CW'(T_WR + T_RP - 1); succ = S_IDLE;     end
         default:     begin dwell = '0;                   succ = S_INIT_WAIT; end
      endcase
   end

   // state sequencing; IDLE gives refresh priority over writes
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      hs      = 1'b0;
      ref_ack = 1'b0;
      if (state_q == S_IDLE) begin
         cnt_d = '0;
         if (ref_pend) begin
            state_d = S_REFRESH;
            ref_ack = 1'b1;
         end else if (wr_valid && rdy_q) begin
            state_d = S_ACTIVATE;
            hs      = 1'b1;
         end
      end else if (cnt_q == dwell) begin
         state_d = succ;
         cnt_d   = '0;
      end
   end

   // burst latches, address counter, and status flags
   always_comb begin
      baddr_d = hs ? addr_q : baddr_q;
      data_d  = hs ? wr_data : data_q;
      addr_d  = addr_q;
      if (clear) addr_d = '0;
      else if (state_q == S_WRITE1) addr_d = addr_q + 25'd2;
      rdy_d  = (state_d == S_IDLE) && !ref_pend_d;
      init_d = init_q | (state_d == S_IDLE);
   end

   // pin values for the cycle the FSM is entering
   always_comb begin
      cmd_d = CMD_NOP;
      a_d   = '0;
      ba_d  = '0;
      oe_d  = 1'b0;
      dq_d  = '0;
      first = (cnt_d == '0);
      unique case (state_d)
         S_PRE_ALL: if (first) begin
            cmd_d  = CMD_PRE;
            a_d[10] = 1'b1;
         end
         S_REF1, S_REF2, S_REFRESH: if (first) cmd_d = CMD_REF;
         S_MRS: if (first) begin
            cmd_d = CMD_MRS;
            a_d   = MRS_VAL;
         end
         S_ACTIVATE: if (first) begin
            cmd_d = CMD_ACT;
            ba_d  = baddr_d[11:10];
            a_d   = baddr_d[24:12];
         end
         S_WRITE0: begin
            cmd_d = CMD_WR;
            ba_d  = baddr_d[11:10];
            a_d   = {2'b00, 1'b1, baddr_d[9:0]};
            oe_d  = 1'b1;
            dq_d  = data_d[15:0];
         end
         S_WRITE1: begin
            oe_d = 1'b1;
            dq_d = data_d[31:16];
         end
         default: cmd_d = CMD_NOP;
      endcase
   end

   // all state and pin registers; reset aborts any burst
   always_ff @(posedge ck143) begin
      if (reset) begin
         state_q <= S_INIT_WAIT;
         cnt_q   <= '0;
         cmd_q   <= CMD_DESL;
         a_q     <= '0;
         ba_q    <= '0;
         oe_q    <= 1'b0;
         dq_q    <= '0;
         rdy_q   <= 1'b0;
         init_q  <= 1'b0;
         addr_q  <= '0;
         baddr_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         a_q     <= a_d;
         ba_q    <= ba_d;
         oe_q    <= oe_d;
         dq_q    <= dq_d;
         rdy_q   <= rdy_d;
         init_q  <= init_d;
         addr_q  <= addr_d;
         baddr_q <= baddr_d;
         data_q  <= data_d;
      end
   end

   wire [3:0] cmd_w = cmd_q;
   wire [24:0] wr_addr_q = addr_q;
   wire dq_oe_q = oe_q;

   assign mem_dq    = dq_oe_q ? dq_q : 16'hzzzz;
   assign mem_cs_n  = cmd_w[3];
   assign mem_ras_n = cmd_w[2];
   assign mem_cas_n = cmd_w[1];
   assign mem_we_n  = cmd_w[0];
   assign mem_a     = a_q;
   assign mem_ba    = ba_q;
   assign mem_cke   = 1'b1;
   assign mem_ldqm  = 1'b0;
   assign mem_udqm  = 1'b0;
   assign wr_ready  = rdy_q;
   assign init_done = init_q;
   assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Bench for sdram_burst_writer: init sequence, table of bursts,
// randomized traffic against a queue model, reset mid-burst.
module tb_sdram_burst_writer;

   localparam logic [3:0] C_DESL = 4'b1111;
   localparam logic [3:0] C_NOP  = 4'b0111;
   localparam logic [3:0] C_ACT  = 4'b0011;
   localparam logic [3:0] C_WR   = 4'b0100;
   localparam logic [3:0] C_PRE  = 4'b0010;
   localparam logic [3:0] C_REF  = 4'b0001;
   localparam logic [3:0] C_MRS  = 4'b0000;
   localparam int RINT = 1100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        wr_valid = 1'b0;
   logic [31:0] wr_data = '0;
   wire         wr_ready, init_done;
   wire  [24:0] wr_addr;
   wire  [15:0] mem_dq;
   wire  [12:0] mem_a;
   wire  [1:0]  mem_ba;
   wire         mem_cke, mem_ldqm, mem_udqm;
   wire         mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n;

   sdram_burst_writer dut (
      .ck143    (clk),
      .reset    (reset),
      .clear    (clear),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .init_done(init_done),
      .wr_addr  (wr_addr),
      .mem_dq   (mem_dq),
      .mem_a    (mem_a),
      .mem_ba   (mem_ba),
      .mem_cke  (mem_cke),
      .mem_ldqm (mem_ldqm),
      .mem_udqm (mem_udqm),
      .mem_cs_n (mem_cs_n),
      .mem_ras_n(mem_ras_n),
      .mem_cas_n(mem_cas_n),
      .mem_we_n (mem_we_n)
   );

   always #3 clk = ~clk;

   wire [3:0] cmd = {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n};
   wire       oe  = dut.dq_oe_q;

   typedef struct {
      logic        frc;
      logic [24:0] faddr;
      logic [31:0] d;
      logic [12:0] row;
      logic [1:0]  bank;
      logic [9:0]  col;
      logic [24:0] nxt;
      int          clr;
   } vec_t;

   typedef struct {
      logic [24:0] a;
      logic [31:0] d;
   } exp_t;

   vec_t        tbl [9];
   exp_t        exp_q [$];
   int          vec = 0;
   int          bad = 0;
   logic [24:0] frc_val;
   logic [24:0] m_addr;
   logic        mon_on;
   int          hs_cnt, nwr, nref;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_cmd", cmd, C_DESL);
      chk("rst_a", mem_a, 0);
      chk("rst_ba", mem_ba, 0);
      chk("rst_pins", {mem_cke, mem_ldqm, mem_udqm}, 3'b100);
      chk("rst_dq_z", oe, 0);
      chk("rst_rdy", wr_ready, 0);
      chk("rst_init", init_done, 0);
      chk("rst_addr", wr_addr, 0);
   endtask

   task automatic gap(output int g);
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (cmd == C_NOP && g < 100);
   endtask

   // called at the negedge where reset was just released
   task automatic init_seq();
      int n, g;
      n = 0;
      @(negedge clk);
      while (cmd == C_NOP && n < 20000) begin
         n++;
         @(negedge clk);
      end
      chk("init_nops", n, 14300);
      chk("pre_cmd", cmd, C_PRE);
      chk("pre_a10", mem_a[10], 1);
      gap(g);
      chk("pre_ref_gap", g, 3);
      chk("ref1_cmd", cmd, C_REF);
      gap(g);
      chk("ref_ref_gap", g, 9);
      chk("ref2_cmd", cmd, C_REF);
      gap(g);
      chk("ref_mrs_gap", g, 9);
      chk("mrs_cmd", cmd, C_MRS);
      chk("mrs_a", mem_a, 13'h021);
      @(negedge clk);
      chk("init_early", init_done, 0);
      @(negedge clk);
      @(negedge clk);
      chk("init_done", init_done, 1);
      chk("init_rdy", wr_ready, 1);
   endtask

   task automatic wr_pair(input vec_t v);
      int n;
      logic r;
      if (v.frc) begin
         @(negedge clk);
         frc_val = v.faddr;
         force dut.addr_q = frc_val;
         @(posedge clk);
         #1 release dut.addr_q;
      end
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = v.d;
      n = 0;
      while (!wr_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("hs_wait", n < 2000, 1);
      @(negedge clk);
      wr_valid = 1'b0;
      chk("act_cmd", cmd, C_ACT);
      chk("act_ba", mem_ba, v.bank);
      chk("act_row", mem_a, v.row);
      chk("act_rdy", wr_ready, 0);
      @(negedge clk);
      chk("rcd_nop1", cmd, C_NOP);
      @(negedge clk);
      chk("rcd_nop2", cmd, C_NOP);
      @(negedge clk);
      chk("wr_cmd", cmd, C_WR);
      chk("wr_a", mem_a, {3'b001, v.col});
      chk("wr_ba", mem_ba, v.bank);
      chk("wr_oe", oe, 1);
      chk("wr_dq_lo", mem_dq, v.d[15:0]);
      @(negedge clk);
      chk("w1_nop", cmd, C_NOP);
      chk("w1_oe", oe, 1);
      chk("w1_dq_hi", mem_dq, v.d[31:16]);
      if (v.clr == 2) clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("addr_next", wr_addr, v.nxt);
      chk("rec_dq_z", oe, 0);
      if (v.clr == 1) begin
         clear = 1'b1;
         @(negedge clk);
         clear = 1'b0;
         chk("addr_clr", wr_addr, 0);
         repeat (3) @(negedge clk);
      end else begin
         repeat (4) @(negedge clk);
      end
      chk("rec_rdy", wr_ready, 0);
      @(negedge clk);
      r = wr_ready;
      if (!r) begin
         @(negedge clk);
         r = (cmd == C_REF);
      end
      chk("rdy_10", r, 1);
   endtask

   // bus monitor: protocol timing plus queue scoreboard
   task automatic monitor();
      int t, last_rc, last_act, last_ref, t_wr;
      logic [12:0] arow;
      logic [1:0]  abank;
      exp_t e;
      t = 0;
      last_rc = -100;
      last_act = -100;
      last_ref = -100;
      t_wr = -100;
      e = '{a: '0, d: '0};
      arow = '0;
      abank = '0;
      while (mon_on) begin
         @(negedge clk);
         t++;
         if (t == t_wr + 1) chk("m_dq_hi", mem_dq, e.d[31:16]);
         if (cmd == C_ACT) begin
            chk("m_act_trc", t - last_rc >= 9, 1);
            last_rc = t;
            last_act = t;
            arow = mem_a;
            abank = mem_ba;
         end else if (cmd == C_REF) begin
            chk("m_ref_trc", t - last_rc >= 9, 1);
            chk("m_ref_dq_z", oe, 0);
            if (nref > 0)
               chk("m_ref_int", (t - last_ref >= RINT - 12) &&
                                (t - last_ref <= RINT + 12), 1);
            last_rc = t;
            last_ref = t;
            nref++;
         end else if (cmd == C_WR) begin
            chk("m_rcd", t - last_act, 3);
            if (exp_q.size() == 0) begin
               chk("m_wr_unexpected", 0, 1);
            end else begin
               e = exp_q.pop_front();
               chk("m_wr_addr", {arow, abank, mem_a[9:0]}, e.a);
               chk("m_wr_bank", mem_ba, abank);
               chk("m_wr_ap", mem_a[10], 1);
               chk("m_dq_lo", mem_dq, e.d[15:0]);
            end
            t_wr = t;
            nwr++;
         end
      end
   endtask

   task automatic driver();
      logic acc;
      acc = 1'b0;
      wr_data = $urandom;
      for (int c = 0; c < 3500; c++) begin
         @(negedge clk);
         if (acc) wr_data = $urandom;
         if (c < 1500) wr_valid = 1'b1;
         else wr_valid = ($urandom_range(0, 3) != 0);
         acc = wr_valid && wr_ready;
         if (acc) begin
            exp_q.push_back('{a: m_addr, d: wr_data});
            m_addr = m_addr + 25'd2;
            hs_cnt++;
         end
      end
      @(negedge clk);
      wr_valid = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   initial begin
      vec_t v;
      tbl[0] = '{1'b0, 25'h0,       32'hBEEF_1234, 13'h0,    2'd0, 10'h0,   25'h2,       0};
      tbl[1] = '{1'b0, 25'h0,       32'hA5A5_5A5A, 13'h0,    2'd0, 10'h2,   25'h4,       0};
      tbl[2] = '{1'b1, 25'h3FE,     32'h1111_2222, 13'h0,    2'd0, 10'h3FE, 25'h400,     0};
      tbl[3] = '{1'b0, 25'h0,       32'h3333_4444, 13'h0,    2'd1, 10'h0,   25'h402,     0};
      tbl[4] = '{1'b1, 25'h1FFFFFE, 32'h5555_6666, 13'h1FFF, 2'd3, 10'h3FE, 25'h0,       0};
      tbl[5] = '{1'b1, 25'h0ABCD56, 32'h6666_7777, 13'h0ABC, 2'd3, 10'h156, 25'h0ABCD58, 0};
      tbl[6] = '{1'b1, 25'h6,       32'h7777_8888, 13'h0,    2'd0, 10'h6,   25'h8,       1};
      tbl[7] = '{1'b0, 25'h0,       32'h9999_AAAA, 13'h0,    2'd0, 10'h0,   25'h0,       2};
      tbl[8] = '{1'b0, 25'h0,       32'hCCCC_DDDD, 13'h0,    2'd0, 10'h0,   25'h2,       0};

      repeat (2) @(negedge clk);
      chk_reset();
      reset = 1'b0;
      init_seq();

      for (int i = 0; i < 9; i++) wr_pair(tbl[i]);

      m_addr = 25'h2;
      hs_cnt = 0;
      nwr = 0;
      nref = 0;
      mon_on = 1'b1;
      fork
         begin
            driver();
            mon_on = 1'b0;
         end
         monitor();
      join
      chk("r_hs_vs_wr", nwr, hs_cnt);
      chk("r_q_empty", exp_q.size(), 0);
      chk("r_addr", wr_addr, m_addr);
      chk("r_ref_seen", nref >= 3, 1);

      @(negedge clk);
      wr_valid = 1'b1;
      wr_data = 32'h0F0F_F0F0;
      for (int n = 0; n < 2000 && !wr_ready; n++) @(negedge clk);
      @(negedge clk);
      wr_valid = 1'b0;
      chk("x_act", cmd, C_ACT);
      repeat (3) @(negedge clk);
      chk("x_wr", cmd, C_WR);
      @(negedge clk);
      chk("x_w1_oe", oe, 1);
      reset = 1'b1;
      @(negedge clk);
      chk_reset();
      @(negedge clk);
      reset = 1'b0;
      init_seq();
      v = '{1'b0, 25'h0, 32'h1357_9BDF, 13'h0, 2'd0, 10'h0, 25'h2, 0};
      wr_pair(v);

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
